version_string_reader: RTL and testbench
========================================

# version_string_reader

Bus initiator that fetches the build version string from the version string register block and streams it out one ASCII character at a time over a valid/ready interface, typically into the UART transmitter for a boot banner. A `start_i` pulse triggers it. It issues sequential read cycles on the simple address/data/`rd_wr` bus and unpacks each returned word into characters. It is the reading end of the version string read path and owns the bus only while `busy_o` is high.

## Interface
- `BaseAddress`, 0: bus address of character word 0 in the version string block.
- `NumCharacters`, 44: total characters in the string.
- `CharsPerTransaction`, 1: characters carried per bus word.
- `address_width`, 15: bus address width.
- `data_width`, 16: bus data width; must be ≥ 8*`CharsPerTransaction`.
- `Address_Wording`, 1: address stride between consecutive words.
- `ReadLatency`, 1: clock edges from address change to valid `data_i`.
- `SkipNul`, 1: 1 drops 0x00 characters from the stream.
- `clk_i`  in  1  system clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  single-cycle start request; ignored while `busy_o` is high.
- `busy_o`  out  1  high from start acceptance until `done_o`.
- `done_o`  out  1  one-cycle pulse after the final character is accepted.
- `address_o`  out  `address_width`  bus read address (registered).
- `data_i`  in  `data_width`  bus read data from the responder.
- `data_o`  out  `data_width`  bus write data; constant 0.
- `rd_wr_o`  out  1  0 = read; constant 0.
- `char_o`  out  8  current character.
- `char_valid_o`  out  1  `char_o` is valid.
- `char_ready_i`  in  1  downstream accepts `char_o` when high with `char_valid_o`.

## Operation
- Number of words: `NumWords` = `NumCharacters`/`CharsPerTransaction`. Non-integer division is an elaboration error.
- States:
  - IDLE: waits for `start_i`.
  - FETCH: waits out the read latency, then captures the word.
  - EMIT: serialises the captured word.
  - DONE: one cycle, then IDLE.
- IDLE → FETCH on `start_i`. At that edge, `address_o` ← `BaseAddress`, word index ← 0, latency counter ← 0.
- FETCH:
  - Lasts exactly `ReadLatency`+1 cycles.
  - `data_i` is captured into the word register on the last FETCH edge; character index ← 0.
  - Then → EMIT.
- Word layout: characters occupy `data_i`[8*`CharsPerTransaction`-1:0], most-significant character first. Upper bits are ignored.
- EMIT:
  - `char_o` = selected byte of the captured word.
  - `char_valid_o` = 1 unless the byte is 0x00 and `SkipNul`=1.
  - A character advances when `char_valid_o`&&`char_ready_i` is true, or when the character is a skipped NUL (one cycle per skipped NUL).
  - After the last character of a word:
    - If this is the final word, → DONE.
    - Otherwise `address_o` += `Address_Wording`, word index++, and → FETCH.
- DONE: `done_o`=1 for one cycle, `busy_o` deasserts in the same cycle, then → IDLE.
- Once `char_valid_o` is asserted, it and `char_o` hold stable until accepted.
- `address_o` holds its last value in IDLE.
- Address arithmetic is modulo 2^`address_width` (wraps silently).

## Timing
- Reset values:
  - `busy_o`=0, `done_o`=0, `char_valid_o`=0.
  - `char_o`=0, `address_o`=0, `data_o`=0, `rd_wr_o`=0.
  - State = IDLE.
- Reset asserted mid-operation aborts immediately and restores all reset values; no `done_o` is produced.
- First `char_valid_o`: `ReadLatency`+1 cycles after the start-accept edge (2 cycles at defaults).
- With `char_ready_i` held high and no NULs skipped, each word takes `ReadLatency`+1+`CharsPerTransaction` cycles. At defaults the whole string takes 44×3 = 132 cycles, and `done_o` follows one cycle after the last acceptance.
- `char_ready_i` low stalls indefinitely; `address_o` is stable during the stall.
- `start_i` coincident with DONE is ignored; a new transfer needs `start_i` in IDLE.

## Structure
- Shared package `version_reader_pkg` holds:
  - the state enum typedef (IDLE, FETCH, EMIT, DONE);
  - the read/write encoding constants (`RD`=0, `WR`=1), so they are shared with the responder.
- No sub-module; the serialiser is a few lines inside the FSM.
- The bench pairs this block with the version string register block as the responder.

## Test plan
- String "v1.0", `NumCharacters`=4, `CharsPerTransaction`=1, `ReadLatency`=1, `BaseAddress`=0x100, ready tied high, pulse `start_i` → `address_o` takes 0x100, 0x101, 0x102, 0x103; characters 0x76, 0x31, 0x2E, 0x30; `done_o` 13 cycles after start.
- Same string, `CharsPerTransaction`=2, `data_width`=16 → two reads at 0x100/0x101; characters in order 0x76, 0x31, 0x2E, 0x30.
- `char_ready_i` low for 10 cycles at the second character → `char_valid_o` and `char_o`=0x31 held stable throughout; no duplicated or dropped characters.
- String "ab\0c", `SkipNul`=1 → stream 0x61, 0x62, 0x63. With `SkipNul`=0 → 0x61, 0x62, 0x00, 0x63.
- `start_i` re-pulsed while busy → ignored; exactly one `done_o`, 4 characters.
- `reset_i` asserted during EMIT of the third character → all outputs at reset values in the same cycle; a fresh `start_i` then produces the complete string.

Source files
------------

// File: rtl/version_reader_pkg.sv
// Shared definitions for the version string read path: reader FSM states and
// the bus read/write encoding used by both initiator and responder.
package version_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic RD = 1'b0;
   localparam logic WR = 1'b1;

endpackage

// File: rtl/version_string_reader.sv
// Fetches the version string word by word over the simple read bus and streams
// it out one ASCII character per valid/ready handshake.
module version_string_reader
   import version_reader_pkg::*;
#(
   parameter int BaseAddress         = 0,
   parameter int NumCharacters       = 44,
   parameter int CharsPerTransaction = 1,
   parameter int address_width       = 15,
   parameter int data_width          = 16,
   parameter int Address_Wording     = 1,
   parameter int ReadLatency         = 1,
   parameter int SkipNul             = 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [address_width-1:0] address_o,
   input  logic [data_width-1:0]    data_i,
   output logic [data_width-1:0]    data_o,
   output logic                     rd_wr_o,
   output logic [7:0]               char_o,
   output logic                     char_valid_o,
   input  logic                     char_ready_i
);

   localparam int NumWords = NumCharacters / CharsPerTransaction;
   localparam int WordW    = 8 * CharsPerTransaction;
   localparam int LatW     = $clog2(ReadLatency + 2);
   localparam int CharW    = $clog2(CharsPerTransaction + 1);
   localparam int WIdxW    = $clog2(NumWords + 1);

   generate
      if (NumCharacters % CharsPerTransaction != 0) begin : g_bad_split
         $error("NumCharacters must be a multiple of CharsPerTransaction");
      end
      if (data_width < WordW) begin : g_bad_width
         $error("data_width too narrow for CharsPerTransaction");
      end
   endgenerate

   state_t             state;
   logic [LatW-1:0]    lat_cnt;
   logic [CharW-1:0]   char_idx;
   logic [WIdxW-1:0]   word_idx;
   logic [WordW-1:0]   word_q;
   logic [7:0]         first_char;
   logic [7:0]         next_char;
   logic               advance;
   logic               unused_data;

   // Character 0 is the most significant byte of the character field.
   function automatic logic [7:0] pick_char(input logic [WordW-1:0] w,
                                            input logic [CharW-1:0] idx);
      logic [WordW-1:0] sh;
      sh = w >> (8 * (CharsPerTransaction - 1 - int'(idx)));
      return sh[7:0];
   endfunction

   function automatic logic shown(input logic [7:0] c);
      return !((SkipNul != 0) && (c == 8'h00));
   endfunction

   assign first_char  = pick_char(data_i[WordW-1:0], '0);
   assign next_char   = pick_char(word_q, char_idx + 1'b1);
   assign advance     = char_valid_o ? char_ready_i : 1'b1;
   assign data_o      = '0;
   assign rd_wr_o     = RD;
   assign unused_data = ^data_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state        <= IDLE;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         address_o    <= '0;
         char_o       <= '0;
         char_valid_o <= 1'b0;
         lat_cnt      <= '0;
         char_idx     <= '0;
         word_idx     <= '0;
         word_q       <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state     <= FETCH;
                  busy_o    <= 1'b1;
                  address_o <= address_width'(BaseAddress);
                  word_idx  <= '0;
                  lat_cnt   <= '0;
               end
            end
            FETCH: begin
               if (lat_cnt == LatW'(ReadLatency)) begin
                  word_q       <= data_i[WordW-1:0];
                  char_idx     <= '0;
                  char_o       <= first_char;
                  char_valid_o <= shown(first_char);
                  state        <= EMIT;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            EMIT: begin
               // A skipped NUL is never valid, so it drains in a single cycle.
               if (advance) begin
                  if (char_idx == CharW'(CharsPerTransaction - 1)) begin
                     char_valid_o <= 1'b0;
                     if (word_idx == WIdxW'(NumWords - 1)) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                     end else begin
                        address_o <= address_o + address_width'(Address_Wording);
                        word_idx  <= word_idx + 1'b1;
                        lat_cnt   <= '0;
                        state     <= FETCH;
                     end
                  end else begin
                     char_idx     <= char_idx + 1'b1;
                     char_o       <= next_char;
                     char_valid_o <= shown(next_char);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_version_string_reader.sv
// Bench: three reader configurations against a modelled version string
// responder, with a character/address scoreboard.
module tb_version_string_reader;

   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  ch;
   } item_t;

   logic        clk;
   logic        rst;
   logic        start [3];
   logic        rdy   [3];
   logic        bz    [3];
   logic        dn    [3];
   logic [14:0] ad    [3];
   logic [15:0] rdata [3];
   logic [15:0] dw    [3];
   logic        rw    [3];
   logic [7:0]  co    [3];
   logic        cv    [3];
   logic [7:0]  str   [4];

   item_t exp_q [3][$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    done_cnt [3];
   int    done_cyc [3];
   bit    mon_en = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   version_string_reader #(.BaseAddress(256), .NumCharacters(4), .CharsPerTransaction(1),
      .address_width(15), .data_width(16), .Address_Wording(1), .ReadLatency(1), .SkipNul(1))
   u_a (.clk_i(clk), .reset_i(rst), .start_i(start[0]), .busy_o(bz[0]), .done_o(dn[0]),
      .address_o(ad[0]), .data_i(rdata[0]), .data_o(dw[0]), .rd_wr_o(rw[0]),
      .char_o(co[0]), .char_valid_o(cv[0]), .char_ready_i(rdy[0]));

   version_string_reader #(.BaseAddress(256), .NumCharacters(4), .CharsPerTransaction(2),
      .address_width(15), .data_width(16), .Address_Wording(1), .ReadLatency(1), .SkipNul(1))
   u_b (.clk_i(clk), .reset_i(rst), .start_i(start[1]), .busy_o(bz[1]), .done_o(dn[1]),
      .address_o(ad[1]), .data_i(rdata[1]), .data_o(dw[1]), .rd_wr_o(rw[1]),
      .char_o(co[1]), .char_valid_o(cv[1]), .char_ready_i(rdy[1]));

   version_string_reader #(.BaseAddress(256), .NumCharacters(4), .CharsPerTransaction(1),
      .address_width(15), .data_width(16), .Address_Wording(1), .ReadLatency(1), .SkipNul(0))
   u_c (.clk_i(clk), .reset_i(rst), .start_i(start[2]), .busy_o(bz[2]), .done_o(dn[2]),
      .address_o(ad[2]), .data_i(rdata[2]), .data_o(dw[2]), .rd_wr_o(rw[2]),
      .char_o(co[2]), .char_valid_o(cv[2]), .char_ready_i(rdy[2]));

   function automatic logic [7:0] sbyte(input int idx);
      return (idx >= 0 && idx < 4) ? str[idx] : 8'h00;
   endfunction

   // Responder: one register stage of latency; upper byte is junk for 1-char words.
   always_ff @(posedge clk) begin
      rdata[0] <= {8'hA5, sbyte(int'(ad[0]) - 256)};
      rdata[1] <= {sbyte(2 * (int'(ad[1]) - 256)), sbyte(2 * (int'(ad[1]) - 256) + 1)};
      rdata[2] <= {8'h5A, sbyte(int'(ad[2]) - 256)};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      item_t it;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (mon_en && cv[i] && rdy[i]) begin
            chk($sformatf("char_expected_inst%0d", i), 32'(exp_q[i].size() != 0), 32'd1);
            if (exp_q[i].size() != 0) begin
               it = exp_q[i].pop_front();
               chk($sformatf("char_inst%0d", i), 32'(co[i]), 32'(it.ch));
               chk($sformatf("addr_inst%0d", i), 32'(ad[i]), 32'(it.addr));
            end
         end
         if (dn[i]) begin
            done_cnt[i]++;
            done_cyc[i] = cyc;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_str(input int i, input int cpt, input bit skip);
      item_t it;
      exp_q[i].delete();
      done_cnt[i] = 0;
      for (int k = 0; k < 4; k++) begin
         if (!(skip && str[k] == 8'h00)) begin
            it.addr = 15'(256 + k / cpt);
            it.ch   = str[k];
            exp_q[i].push_back(it);
         end
      end
   endtask

   task automatic run(input int i, input int budget, output int s);
      int n;
      start[i] = 1'b1;
      cycle();
      s = cyc;
      start[i] = 1'b0;
      n = 0;
      while (done_cnt[i] == 0 && n < budget) begin
         cycle();
         n++;
      end
      for (int k = 0; k < 3; k++) cycle();
   endtask

   task automatic set_str(input logic [31:0] s4);
      for (int k = 0; k < 4; k++) str[k] = s4[31-8*k -: 8];
   endtask

   task automatic end_checks(input int i, input string tag);
      chk({tag, "_queue_empty"}, 32'(exp_q[i].size()), 32'd0);
      chk({tag, "_done_count"}, 32'(done_cnt[i]), 32'd1);
      chk({tag, "_busy_idle"}, 32'(bz[i]), 32'd0);
   endtask

   task automatic reset_checks(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_busy%0d", tag, i), 32'(bz[i]), 32'd0);
         chk($sformatf("%s_done%0d", tag, i), 32'(dn[i]), 32'd0);
         chk($sformatf("%s_valid%0d", tag, i), 32'(cv[i]), 32'd0);
         chk($sformatf("%s_char%0d", tag, i), 32'(co[i]), 32'd0);
         chk($sformatf("%s_addr%0d", tag, i), 32'(ad[i]), 32'd0);
         chk($sformatf("%s_wdata%0d", tag, i), 32'(dw[i]), 32'd0);
         chk($sformatf("%s_rdwr%0d", tag, i), 32'(rw[i]), 32'd0);
      end
   endtask

   initial begin
      int  s;
      int  n;
      bit  stalled;

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0;
         rdy[i] = 1'b1;
         done_cnt[i] = 0;
         done_cyc[i] = 0;
      end
      set_str(32'h76312E30);
      repeat (2) @(posedge clk);
      #1;
      reset_checks("reset");
      rst = 1'b0;
      cycle();

      // "v1.0", one character per word, ready high.
      push_str(0, 1, 1'b1);
      run(0, 40, s);
      end_checks(0, "basic");
      chk("basic_done_latency", 32'(done_cyc[0] - s), 32'd13);
      chk("basic_addr_hold", 32'(ad[0]), 32'h103);

      // Two characters per word.
      push_str(1, 2, 1'b1);
      run(1, 40, s);
      end_checks(1, "wide");
      chk("wide_done_latency", 32'(done_cyc[1] - s), 32'd9);
      chk("wide_addr_hold", 32'(ad[1]), 32'h101);

      // Ready held low for 10 cycles on the second character.
      push_str(0, 1, 1'b1);
      start[0] = 1'b1;
      cycle();
      start[0] = 1'b0;
      stalled = 1'b0;
      n = 0;
      while (done_cnt[0] == 0 && n < 80) begin
         if (!stalled && cv[0] && co[0] == 8'h31) begin
            stalled = 1'b1;
            rdy[0] = 1'b0;
            for (int k = 0; k < 10; k++) begin
               cycle();
               chk("stall_valid", 32'(cv[0]), 32'd1);
               chk("stall_char", 32'(co[0]), 32'h31);
               chk("stall_addr", 32'(ad[0]), 32'h101);
            end
            rdy[0] = 1'b1;
         end
         cycle();
         n++;
      end
      for (int k = 0; k < 3; k++) cycle();
      chk("stall_seen", 32'(stalled), 32'd1);
      end_checks(0, "stall");

      // Embedded NUL, skipped and passed through.
      set_str(32'h61620063);
      push_str(0, 1, 1'b1);
      run(0, 40, s);
      end_checks(0, "skipnul");
      push_str(2, 1, 1'b0);
      run(2, 40, s);
      end_checks(2, "keepnul");

      // start re-pulsed while busy and coincident with DONE.
      set_str(32'h76312E30);
      push_str(0, 1, 1'b1);
      start[0] = 1'b1;
      cycle();
      n = 0;
      while (n < 60) begin
         start[0] = (bz[0] && (n % 3 == 0)) || dn[0];
         cycle();
         n++;
      end
      start[0] = 1'b0;
      end_checks(0, "repulse");

      // Reset while the third character is on offer, then a clean restart.
      mon_en = 1'b0;
      exp_q[0].delete();
      done_cnt[0] = 0;
      start[0] = 1'b1;
      cycle();
      start[0] = 1'b0;
      n = 0;
      while (!(cv[0] && co[0] == 8'h2E) && n < 40) begin
         cycle();
         n++;
      end
      chk("abort_reached_third", 32'(co[0]), 32'h2E);
      rst = 1'b1;
      #1;
      reset_checks("abort");
      cycle();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) cycle();
      chk("abort_no_done", 32'(done_cnt[0]), 32'd0);
      chk("abort_idle_valid", 32'(cv[0]), 32'd0);
      mon_en = 1'b1;
      push_str(0, 1, 1'b1);
      run(0, 40, s);
      end_checks(0, "restart");
      chk("restart_done_latency", 32'(done_cyc[0] - s), 32'd13);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
